wb_stage: RTL and testbench

MEM/WB pipeline register and write-back formatter for the 5-stage RISC-V core. It captures the MEM-stage result at each clock edge and, in the WB stage, forms the three write signals for the register file. Those signals are the write enable (RFWr), the destination index (A3) and the write data (WD). WD is selected from the ALU, load, PC+4 or immediate path, with load byte/halfword extraction and extension. The block also flags misaligned loads and maintains the retired-instruction counter.

---
 rtl/wb_stage.sv | 172 +++++++++++++++++
 tb/tb_wb_stage.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_stage.sv
// ---------------------------------------------------------------------------
// wb_stage: MEM/WB pipeline register and write-back formatter.
//
// Captures the MEM-stage result on each clock edge. From the registered copy
// it forms the register-file write signals (RFWr, A3, WD) combinationally:
// load byte/halfword extraction with sign/zero extension, misaligned-load
// detection, and the retired-instruction counter.
//
// Ports
//   clk, rst        clock; asynchronous active-high reset
//   stall           hold the WB register contents
//   flush           load a bubble (valid=0); takes priority over stall
//   m_valid         MEM-stage instruction is valid
//   m_rfwr, m_rd    instruction writes rd / destination index
//   m_wdsel         write-data select: 00 ALU, 01 load, 10 PC+4, 11 imm
//   m_ld_type       load funct3 (000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu)
//   m_alu_out       ALU result; also the load address
//   m_pc, m_imm     instruction PC / immediate
//   m_dmem_rdata    aligned data-memory word read in MEM
//   RFWr, A3, WD    register-file write enable, index, data
//   w_valid         WB stage holds a valid instruction
//   w_misalign      WB instruction is a misaligned load
//   instret         retired-instruction count (CNT_W bits, wraps)
// ---------------------------------------------------------------------------
module wb_stage #(
    parameter int CNT_W = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             flush,
    input  logic             m_valid,
    input  logic             m_rfwr,
    input  logic [4:0]       m_rd,
    input  logic [1:0]       m_wdsel,
    input  logic [2:0]       m_ld_type,
    input  logic [31:0]      m_alu_out,
    input  logic [31:0]      m_pc,
    input  logic [31:0]      m_imm,
    input  logic [31:0]      m_dmem_rdata,
    output logic             RFWr,
    output logic [4:0]       A3,
    output logic [31:0]      WD,
    output logic             w_valid,
    output logic             w_misalign,
    output logic [CNT_W-1:0] instret
);

    // Misaligned-load condition; only loads (wdsel=01) can be misaligned.
    // Encodings 011/110/111 fall into the lw group.
    function automatic logic misalign_f(input logic [1:0] wdsel,
                                        input logic [2:0] ld_type,
                                        input logic [1:0] off);
        logic mis;
        mis = 1'b0;
        if (wdsel == 2'b01) begin
            case (ld_type)
                3'b000, 3'b100: mis = 1'b0;
                3'b001, 3'b101: mis = off[0];
                default:        mis = (off != 2'b00);
            endcase
        end else begin
            mis = 1'b0;
        end
        return mis;
    endfunction

    // Byte/halfword lane selection and extension from the aligned word.
    function automatic logic [31:0] load_extract_f(input logic [2:0]  ld_type,
                                                   input logic [1:0]  off,
                                                   input logic [31:0] rdata);
        logic [7:0]  byte_v;
        logic [15:0] half_v;
        logic [31:0] res;
        case (off)
            2'b00:   byte_v = rdata[7:0];
            2'b01:   byte_v = rdata[15:8];
            2'b10:   byte_v = rdata[23:16];
            2'b11:   byte_v = rdata[31:24];
            default: byte_v = rdata[7:0];
        endcase
        half_v = off[1] ? rdata[31:16] : rdata[15:0];
        case (ld_type)
            3'b000:  res = {{24{byte_v[7]}}, byte_v};
            3'b100:  res = {24'h000000, byte_v};
            3'b001:  res = {{16{half_v[15]}}, half_v};
            3'b101:  res = {16'h0000, half_v};
            default: res = rdata;
        endcase
        return res;
    endfunction

    logic        valid_r;
    logic        rfwr_r;
    logic [4:0]  rd_r;
    logic [1:0]  wdsel_r;
    logic [2:0]  ld_type_r;
    logic [31:0] alu_out_r;
    logic [31:0] pc4_r;
    logic [31:0] imm_r;
    logic [31:0] rdata_r;
    logic [CNT_W-1:0] instret_r;

    logic        m_misalign_s;
    logic        capture_s;
    logic        misalign_s;
    logic [31:0] load_data_s;
    logic [31:0] wd_s;

    // Incoming instruction's misalignment decides whether it retires on capture.
    assign m_misalign_s = misalign_f(m_wdsel, m_ld_type, m_alu_out[1:0]);
    assign capture_s    = ~flush & ~stall;

    // WB pipeline register: rst > flush > stall > load. A flush only clears
    // valid; the payload fields are meaningless behind a bubble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_r   <= 1'b0;
            rfwr_r    <= 1'b0;
            rd_r      <= 5'd0;
            wdsel_r   <= 2'b00;
            ld_type_r <= 3'b000;
            alu_out_r <= 32'h00000000;
            pc4_r     <= 32'h00000000;
            imm_r     <= 32'h00000000;
            rdata_r   <= 32'h00000000;
        end else if (flush) begin
            valid_r   <= 1'b0;
        end else if (!stall) begin
            valid_r   <= m_valid;
            rfwr_r    <= m_rfwr;
            rd_r      <= m_rd;
            wdsel_r   <= m_wdsel;
            ld_type_r <= m_ld_type;
            alu_out_r <= m_alu_out;
            pc4_r     <= m_pc + 32'd4;
            imm_r     <= m_imm;
            rdata_r   <= m_dmem_rdata;
        end
    end

    // Retired-instruction counter: counts valid, non-misaligned captures.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instret_r <= {CNT_W{1'b0}};
        end else if (capture_s && m_valid && !m_misalign_s) begin
            instret_r <= instret_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    // Write-data formatting from the registered WB fields.
    always_comb begin
        load_data_s = load_extract_f(ld_type_r, alu_out_r[1:0], rdata_r);
        misalign_s  = valid_r & misalign_f(wdsel_r, ld_type_r, alu_out_r[1:0]);
        wd_s        = alu_out_r;
        case (wdsel_r)
            2'b00:   wd_s = alu_out_r;
            2'b01:   wd_s = load_data_s;
            2'b10:   wd_s = pc4_r;
            2'b11:   wd_s = imm_r;
            default: wd_s = alu_out_r;
        endcase
    end

    assign WD         = wd_s;
    assign A3         = rd_r;
    assign w_valid    = valid_r;
    assign w_misalign = misalign_s;
    assign RFWr       = valid_r & rfwr_r & (rd_r != 5'd0) & ~misalign_s;
    assign instret    = instret_r;

endmodule

// File: tb/tb_wb_stage.sv
module tb_wb_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        m_valid = 1'b0;
    logic        m_rfwr = 1'b0;
    logic [4:0]  m_rd = 5'd0;
    logic [1:0]  m_wdsel = 2'b00;
    logic [2:0]  m_ld_type = 3'b000;
    logic [31:0] m_alu_out = 32'h0;
    logic [31:0] m_pc = 32'h0;
    logic [31:0] m_imm = 32'h0;
    logic [31:0] m_dmem_rdata = 32'h0;

    logic        RFWr, w_valid, w_misalign;
    logic [4:0]  A3;
    logic [31:0] WD;
    logic [63:0] instret;

    logic        RFWr4, w_valid4, w_misalign4;
    logic [4:0]  A3_4;
    logic [31:0] WD4;
    logic [3:0]  instret4;

    int total = 0;
    int bad   = 0;

    wb_stage #(.CNT_W(64)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .m_valid(m_valid), .m_rfwr(m_rfwr), .m_rd(m_rd), .m_wdsel(m_wdsel),
        .m_ld_type(m_ld_type), .m_alu_out(m_alu_out), .m_pc(m_pc),
        .m_imm(m_imm), .m_dmem_rdata(m_dmem_rdata),
        .RFWr(RFWr), .A3(A3), .WD(WD), .w_valid(w_valid),
        .w_misalign(w_misalign), .instret(instret)
    );

    wb_stage #(.CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .m_valid(m_valid), .m_rfwr(m_rfwr), .m_rd(m_rd), .m_wdsel(m_wdsel),
        .m_ld_type(m_ld_type), .m_alu_out(m_alu_out), .m_pc(m_pc),
        .m_imm(m_imm), .m_dmem_rdata(m_dmem_rdata),
        .RFWr(RFWr4), .A3(A3_4), .WD(WD4), .w_valid(w_valid4),
        .w_misalign(w_misalign4), .instret(instret4)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        v, rf;
        logic [4:0]  rd;
        logic [1:0]  ws;
        logic [2:0]  lt;
        logic [31:0] alu, pc, imm, rdata;
        logic        st, fl;
        logic        e_valid, e_rfwr, e_mis;
        logic [4:0]  e_a3;
        logic [31:0] e_wd;
        int          e_cnt;
    } vec_t;

    vec_t vecs[$];

    // Behavioural model of what WB should show after each edge.
    logic        x_valid, x_rfwr, x_mis;
    logic [4:0]  x_a3;
    logic [31:0] x_wd;
    longint unsigned x_cnt;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic int access_size(input logic [2:0] lt);
        if (lt == 3'b000 || lt == 3'b100) return 1;
        if (lt == 3'b001 || lt == 3'b101) return 2;
        return 4;
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] lt, input int off,
                                             input logic [31:0] rdata);
        int size, lane, val;
        logic [31:0] w;
        size = access_size(lt);
        if (size == 4) return rdata;
        lane = off / size;
        w = rdata >> (8 * size * lane);
        if (size == 1) begin
            val = int'(w % 32'd256);
            if (lt == 3'b000 && val >= 128) val = val - 256;
        end else begin
            val = int'(w % 32'd65536);
            if (lt == 3'b001 && val >= 32768) val = val - 65536;
        end
        return 32'(val);
    endfunction

    function automatic logic ref_mis(input logic [1:0] ws, input logic [2:0] lt,
                                     input logic [31:0] alu);
        int off;
        off = int'(alu % 32'd4);
        return (ws == 2'b01) && ((off % access_size(lt)) != 0);
    endfunction

    task automatic model_reset();
        x_valid = 1'b0; x_rfwr = 1'b0; x_mis = 1'b0;
        x_a3 = 5'd0; x_wd = 32'h0; x_cnt = 0;
    endtask

    // Apply the rules for one posedge using the inputs currently driven.
    task automatic model_edge();
        logic mis;
        if (flush) begin
            x_valid = 1'b0; x_rfwr = 1'b0; x_mis = 1'b0;
        end else if (!stall) begin
            mis = ref_mis(m_wdsel, m_ld_type, m_alu_out);
            x_valid = m_valid;
            x_a3 = m_rd;
            case (m_wdsel)
                2'b00: x_wd = m_alu_out;
                2'b01: x_wd = ref_load(m_ld_type, int'(m_alu_out % 32'd4), m_dmem_rdata);
                2'b10: x_wd = m_pc + 32'd4;
                default: x_wd = m_imm;
            endcase
            x_mis  = m_valid && mis;
            x_rfwr = m_valid && m_rfwr && (m_rd != 5'd0) && !mis;
            if (m_valid && !mis) x_cnt = x_cnt + 1;
        end
    endtask

    task automatic drive(input logic v, input logic rf, input logic [4:0] rd,
                         input logic [1:0] ws, input logic [2:0] lt,
                         input logic [31:0] alu, input logic [31:0] pc,
                         input logic [31:0] imm, input logic [31:0] rdata,
                         input logic st, input logic fl);
        m_valid = v; m_rfwr = rf; m_rd = rd; m_wdsel = ws; m_ld_type = lt;
        m_alu_out = alu; m_pc = pc; m_imm = imm; m_dmem_rdata = rdata;
        stall = st; flush = fl;
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic chk_model();
        chk("w_valid", {63'h0, w_valid}, {63'h0, x_valid});
        chk("RFWr", {63'h0, RFWr}, {63'h0, x_rfwr});
        chk("w_misalign", {63'h0, w_misalign}, {63'h0, x_mis});
        chk("instret", instret, x_cnt);
        chk("instret4", {60'h0, instret4}, x_cnt % 16);
        if (x_valid) begin
            chk("A3", {59'h0, A3}, {59'h0, x_a3});
            chk("WD", {32'h0, WD}, {32'h0, x_wd});
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_RFWr"}, {63'h0, RFWr}, 64'h0);
        chk({tag, "_A3"}, {59'h0, A3}, 64'h0);
        chk({tag, "_WD"}, {32'h0, WD}, 64'h0);
        chk({tag, "_valid"}, {63'h0, w_valid}, 64'h0);
        chk({tag, "_mis"}, {63'h0, w_misalign}, 64'h0);
        chk({tag, "_instret"}, instret, 64'h0);
        chk({tag, "_instret4"}, {60'h0, instret4}, 64'h0);
    endtask

    localparam logic [31:0] RD = 32'h80FF7F01;

    initial begin
        // Asynchronous reset: outputs clear before any clock edge.
        #1 rst = 1'b1;
        #2 chk_zero("reset");
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        //            v    rf   rd     ws     lt      alu           pc            imm           rdata st   fl     valid rfwr mis  a3     wd            cnt
        vecs.push_back('{1'b1,1'b1,5'd5, 2'b00,3'b000,32'h12345678,32'h0,       32'h0,        RD,1'b0,1'b0, 1'b1,1'b1,1'b0,5'd5, 32'h12345678,1});
        vecs.push_back('{1'b1,1'b1,5'd6, 2'b01,3'b000,32'h00001003,32'h0,       32'h0,        RD,1'b0,1'b0, 1'b1,1'b1,1'b0,5'd6, 32'hFFFFFF80,2});
        vecs.push_back('{1'b1,1'b1,5'd6, 2'b01,3'b100,32'h00001001,32'h0,       32'h0,        RD,1'b0,1'b0, 1'b1,1'b1,1'b0,5'd6, 32'h0000007F,3});
        vecs.push_back('{1'b1,1'b1,5'd6, 2'b01,3'b001,32'h00001002,32'h0,       32'h0,        RD,1'b0,1'b0, 1'b1,1'b1,1'b0,5'd6, 32'hFFFF80FF,4});
        vecs.push_back('{1'b1,1'b1,5'd6, 2'b01,3'b101,32'h00001000,32'h0,       32'h0,        RD,1'b0,1'b0, 1'b1,1'b1,1'b0,5'd6, 32'h00007F01,5});
        vecs.push_back('{1'b1,1'b1,5'd6, 2'b01,3'b010,32'h00001000,32'h0,       32'h0,        RD,1'b0,1'b0, 1'b1,1'b1,1'b0,5'd6, 32'h80FF7F01,6});
        vecs.push_back('{1'b1,1'b1,5'd6, 2'b01,3'b010,32'h00001002,32'h0,       32'h0,        RD,1'b0,1'b0, 1'b1,1'b0,1'b1,5'd6, 32'h80FF7F01,6});
        vecs.push_back('{1'b1,1'b1,5'd6, 2'b01,3'b001,32'h00001001,32'h0,       32'h0,        RD,1'b0,1'b0, 1'b1,1'b0,1'b1,5'd6, 32'h00007F01,6});
        vecs.push_back('{1'b1,1'b1,5'd0, 2'b00,3'b000,32'h000000AA,32'h0,       32'h0,        RD,1'b0,1'b0, 1'b1,1'b0,1'b0,5'd0, 32'h000000AA,7});
        vecs.push_back('{1'b1,1'b1,5'd7, 2'b10,3'b000,32'h00000000,32'hFFFFFFFC,32'h0,        RD,1'b0,1'b0, 1'b1,1'b1,1'b0,5'd7, 32'h00000000,8});
        vecs.push_back('{1'b1,1'b1,5'd11,2'b01,3'b011,32'h00001000,32'h0,       32'h0,        RD,1'b0,1'b0, 1'b1,1'b1,1'b0,5'd11,32'h80FF7F01,9});
        vecs.push_back('{1'b1,1'b1,5'd8, 2'b11,3'b000,32'h00000000,32'h0,       32'hDEADB000, RD,1'b0,1'b0, 1'b1,1'b1,1'b0,5'd8, 32'hDEADB000,10});
        // three stalled cycles with different MEM contents: outputs hold
        for (int i = 0; i < 3; i++)
            vecs.push_back('{1'b1,1'b1,5'd9, 2'b00,3'b000,32'h00005555,32'h0,   32'h0,        RD,1'b1,1'b0, 1'b1,1'b1,1'b0,5'd8, 32'hDEADB000,10});
        // flush wins over stall, valid instruction not counted
        vecs.push_back('{1'b1,1'b1,5'd9, 2'b00,3'b000,32'h00005555,32'h0,       32'h0,        RD,1'b1,1'b1, 1'b0,1'b0,1'b0,5'd0, 32'h0,       10});
        vecs.push_back('{1'b1,1'b1,5'd10,2'b00,3'b000,32'h00000777,32'h0,       32'h0,        RD,1'b0,1'b0, 1'b1,1'b1,1'b0,5'd10,32'h00000777,11});
        vecs.push_back('{1'b1,1'b0,5'd12,2'b00,3'b000,32'h00000123,32'h0,       32'h0,        RD,1'b0,1'b0, 1'b1,1'b0,1'b0,5'd12,32'h00000123,12});
        vecs.push_back('{1'b0,1'b1,5'd13,2'b00,3'b000,32'h00000456,32'h0,       32'h0,        RD,1'b0,1'b0, 1'b0,1'b0,1'b0,5'd0, 32'h0,       12});

        foreach (vecs[i]) begin
            drive(vecs[i].v, vecs[i].rf, vecs[i].rd, vecs[i].ws, vecs[i].lt,
                  vecs[i].alu, vecs[i].pc, vecs[i].imm, vecs[i].rdata,
                  vecs[i].st, vecs[i].fl);
            cycle();
            chk($sformatf("vec%0d_valid", i), {63'h0, w_valid}, {63'h0, vecs[i].e_valid});
            chk($sformatf("vec%0d_RFWr", i), {63'h0, RFWr}, {63'h0, vecs[i].e_rfwr});
            chk($sformatf("vec%0d_mis", i), {63'h0, w_misalign}, {63'h0, vecs[i].e_mis});
            chk($sformatf("vec%0d_instret", i), instret, 64'(vecs[i].e_cnt));
            if (vecs[i].e_valid) begin
                chk($sformatf("vec%0d_A3", i), {59'h0, A3}, {59'h0, vecs[i].e_a3});
                chk($sformatf("vec%0d_WD", i), {32'h0, WD}, {32'h0, vecs[i].e_wd});
            end
        end

        // Randomized traffic against the model.
        for (int n = 0; n < 400; n++) begin
            drive(1'($urandom_range(0, 9) != 0), 1'($urandom), 5'($urandom),
                  2'($urandom), 3'($urandom), $urandom, $urandom, $urandom,
                  $urandom, 1'($urandom_range(0, 4) == 0),
                  1'($urandom_range(0, 9) == 0));
            cycle();
            chk_model();
        end

        // Counter wrap on the 4-bit instance: 16 captures bring it back to 0.
        rst = 1'b1;
        #1 chk_zero("rst2");
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        for (int n = 0; n < 16; n++) begin
            drive(1'b1, 1'b1, 5'd3, 2'b00, 3'b000, 32'(n), 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
            cycle();
            chk_model();
        end
        chk("wrap_instret4", {60'h0, instret4}, 64'h0);
        chk("wrap_instret", instret, 64'd16);

        // A few more captures, then reset asserted between edges.
        for (int n = 0; n < 3; n++) begin
            drive(1'b1, 1'b1, 5'd4, 2'b11, 3'b000, 32'h0, 32'h0, 32'hABCD0000, 32'h0, 1'b0, 1'b0);
            cycle();
            chk_model();
        end
        #2 rst = 1'b1;
        #1 chk_zero("midrst");
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        drive(1'b1, 1'b1, 5'd9, 2'b00, 3'b000, 32'hCAFE0001, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
        cycle();
        chk_model();
        chk("post_rst_instret", instret, 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
